cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between NUM_REQ functional-unit result producers: ALU/branch, multiplier, divider and load/store.
- Each producer hands over one data_bus_package_t through a valid/ready handshake into its own one-entry holding register.
- A round-robin arbiter picks one holding entry per cycle and broadcasts it on a registered CDB output to the ROB, PRF, RAT and reservation stations.
- A pipeline flush discards everything the block holds.

Parameters:
- NUM_REQ, 4, number of requesting functional units; must be ≥2; non-power-of-2 values are legal.
- PTR_W, $clog2(NUM_REQ), width of the round-robin pointer (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  mispredict/recovery flush; discards all held and in-flight results.
- req_valid  in  NUM_REQ  per-unit result valid.
- req_pkt  in  NUM_REQ x data_bus_package_t  per-unit result packet.
- req_ready  out  NUM_REQ  per-unit accept; the transfer happens when req_valid[i] & req_ready[i].
- cdb_valid  out  1  registered; a broadcast is present this cycle.
- cdb_pkt  out  data_bus_package_t  registered broadcast packet.
- cdb_src  out  PTR_W  registered index of the unit that produced cdb_pkt.
- grant_oh  out  NUM_REQ  combinational one-hot grant for the current cycle (debug/perf).

Behaviour:
- State:
  - hold_valid[NUM_REQ] and hold_pkt[NUM_REQ].
  - rr_ptr[PTR_W].
  - Output registers cdb_valid, cdb_pkt and cdb_src.
- Reset (rst_n=0, asynchronous):
  - hold_valid=0, rr_ptr=0.
  - cdb_valid=0, cdb_pkt='0, cdb_src=0.
  - req_ready is all ones once reset deasserts.
  - Reset asserted mid-operation drops all held packets with no broadcast.
- Grant (combinational):
  - Scan the hold entries starting at index rr_ptr, upward, wrapping modulo NUM_REQ (not modulo 2^PTR_W).
  - grant_oh is one-hot on the first entry with hold_valid=1.
  - grant_oh is all zero if no entry is held or flush=1.
  - The grant depends only on registered state, so there is no combinational path from req_valid to req_ready.
- Ready:
  - req_ready[i] = ~flush & (~hold_valid[i] | grant_oh[i]).
  - A granted entry can be refilled in the same cycle, so an uncontested unit sustains 1 result/cycle.
- Capture:
  - On req_valid[i] & req_ready[i], the next state is hold_valid[i]=1 and hold_pkt[i]=req_pkt[i].
  - Otherwise a granted entry clears (hold_valid[i]=0).
  - Otherwise the entry holds its value.
- Broadcast:
  - When any grant is asserted: cdb_valid←1, cdb_pkt←hold_pkt[granted], cdb_pkt.execute_valid←1, cdb_src←granted index.
  - Otherwise cdb_valid←0 and cdb_pkt/cdb_src hold their previous values.
  - All packet fields other than execute_valid pass through unmodified (including rob_index, phys_rd, regf_we, current_brat, rvfi).
- Latency:
  - Result accepted in cycle N → earliest cdb_valid in cycle N+2.
  - Entry registered at edge N→N+1, granted in N+1, output registered at edge N+1→N+2.
- Pointer: on a grant to index g, rr_ptr←(g==NUM_REQ-1) ? 0 : g+1. With no grant, rr_ptr holds.
- Fairness: any held entry is broadcast within NUM_REQ cycles of capture.
- Flush (flush=1 in cycle N):
  - No grant and no capture in cycle N.
  - Edge N→N+1 sets all hold_valid=0 and cdb_valid=0.
  - rr_ptr is unchanged.
  - Flush takes precedence over simultaneous req_valid.
- Simultaneous events:
  - Capture and grant on the same entry in one cycle: the new packet replaces the granted one, and hold_valid stays 1.
  - All entries full with no new requests: NUM_REQ consecutive broadcast cycles, in rotation order.
- The CDB has no backpressure; consumers always accept cdb_pkt when cdb_valid=1.

Decomposition:
- Shared package rv32i_types:
  - Reuse data_bus_package_t.
  - Add the constant NUM_CDB_REQ=4.
  - Add requester index localparams CDB_ALU=0, CDB_MUL=1, CDB_DIV=2, CDB_LDST=3.
- Sub-module rr_priority_picker:
  - Parameterised on N.
  - Inputs: request vector and start pointer.
  - Outputs: one-hot grant, binary index and any_grant.
  - Reusable by the reservation-station issue select.

Test Plan:
- Single requester: unit 0 sends a packet with rob_index=5, phys_rd=12, phys_rd_val=0xDEADBEEF, one cycle only → cdb_valid=1 two cycles later, cdb_src=0, fields identical, execute_valid=1, req_ready[0] stays 1.
- Uncontested streaming: unit 2 asserts valid for 8 cycles with rob_index 0..7 → 8 back-to-back broadcasts in order, req_ready[2] never drops, rr_ptr=3 after each grant.
- Full contention: all 4 units assert valid continuously starting with rr_ptr=0 → cdb_src sequence 0,1,2,3,0,1,…; each unit's req_ready is 1 exactly once per 4 cycles.
- Non-power-of-2 wrap: NUM_REQ=3 with all units requesting → cdb_src sequence 0,1,2,0,1,2; rr_ptr never reaches 3.
- Flush: hold units 1 and 3 full, then pulse flush for one cycle together with req_valid[0]=1 → req_ready=0 during flush, no broadcast on the next cycle, all hold_valid=0, rr_ptr unchanged.
- Async reset mid-stream: drop rst_n between clock edges while cdb_valid=1 → cdb_valid=0 immediately (before the next edge), and nothing is broadcast after release until a new request arrives.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Helpers for the CDB arbiter's round-robin pointer.
package cdb_arbiter_pkg;

  // Increment modulo n, which need not be a power of two.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I out-of-order core types: the CDB result packet and CDB requester indices.
package rv32i_types;

  localparam int unsigned ROB_IDX_W  = 5;
  localparam int unsigned PHYS_REG_W = 6;
  localparam int unsigned BRAT_W     = 2;

  localparam int unsigned NUM_CDB_REQ = 4;
  localparam int unsigned CDB_ALU     = 0;
  localparam int unsigned CDB_MUL     = 1;
  localparam int unsigned CDB_DIV     = 2;
  localparam int unsigned CDB_LDST    = 3;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [4:0]  rd_addr;
  } rvfi_t;

  typedef struct packed {
    logic                  execute_valid;
    logic [ROB_IDX_W-1:0]  rob_index;
    logic [PHYS_REG_W-1:0] phys_rd;
    logic [31:0]           phys_rd_val;
    logic                  regf_we;
    logic [BRAT_W-1:0]     current_brat;
    rvfi_t                 rvfi;
  } data_bus_package_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshake and CDB broadcast bundle for the CDB arbiter.
interface cdb_arbiter_if
  import rv32i_types::*;
#(
  parameter int unsigned NUM_REQ = NUM_CDB_REQ
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_valid;
  data_bus_package_t  req_pkt [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  logic               cdb_valid;
  data_bus_package_t  cdb_pkt;
  logic [PTR_W-1:0]   cdb_src;
  logic [NUM_REQ-1:0] grant_oh;

  modport master (
    output req_valid, req_pkt,
    input  req_ready, cdb_valid, cdb_pkt, cdb_src, grant_oh
  );

  modport slave (
    input  req_valid, req_pkt,
    output req_ready, cdb_valid, cdb_pkt, cdb_src, grant_oh
  );
endinterface

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Round-robin picker: first set request at or after start_ptr, wrapping modulo N.
module rr_priority_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start_ptr,
  output logic [N-1:0]         grant_oh,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant
);
  localparam int unsigned IW = $clog2(N);

  int unsigned scan_idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    scan_idx  = 0;
    for (int unsigned off = 0; off < N; off++) begin
      scan_idx = 32'(start_ptr) + off;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!any_grant && req[IW'(scan_idx)]) begin
        any_grant               = 1'b1;
        grant_idx               = IW'(scan_idx);
        grant_oh[IW'(scan_idx)] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry holding register per producer, round-robin pick, registered broadcast.
module cdb_arbiter
  import rv32i_types::*;
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_CDB_REQ
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] hold_valid;
  data_bus_package_t  hold_pkt [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;

  logic               cdb_valid_q;
  data_bus_package_t  cdb_pkt_q;
  logic [PTR_W-1:0]   cdb_src_q;

  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] grant_oh;
  logic [PTR_W-1:0]   grant_idx;
  logic               any_grant;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] capture;
  data_bus_package_t  bcast_pkt;

  // Grant is derived from registered state only; flush suppresses it.
  assign pick_req = flush ? '0 : hold_valid;

  rr_priority_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req       (pick_req),
    .start_ptr (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready = {NUM_REQ{~flush}} & (~hold_valid | grant_oh);
  assign capture   = bus.req_valid & req_ready;

  always_comb begin
    bcast_pkt               = hold_pkt[grant_idx];
    bcast_pkt.execute_valid = 1'b1;
  end

  // Holding-entry occupancy and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      hold_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (capture[i])       hold_valid[i] <= 1'b1;
        else if (grant_oh[i]) hold_valid[i] <= 1'b0;
      end
      if (any_grant) rr_ptr <= PTR_W'(rr_next(32'(grant_idx), NUM_REQ));
    end
  end

  // Payload storage is qualified by hold_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (capture[i]) hold_pkt[i] <= bus.req_pkt[i];
    end
  end

  // Registered CDB broadcast; packet and source hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_pkt_q   <= '0;
      cdb_src_q   <= '0;
    end else if (flush) begin
      cdb_valid_q <= 1'b0;
    end else begin
      cdb_valid_q <= any_grant;
      if (any_grant) begin
        cdb_pkt_q <= bcast_pkt;
        cdb_src_q <= grant_idx;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.grant_oh  = grant_oh;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_pkt   = cdb_pkt_q;
  assign bus.cdb_src   = cdb_src_q;

endmodule
